player_link_rx: RTL and testbench



---
 rtl/player_link_rx.sv | 160 ++++++++++++++++
 tb/tb_player_link_rx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_link_rx.sv
// -----------------------------------------------------------------------------
// player_link_rx
// Receive conditioner for the 6-bit parallel inter-board player link.
// The opponent board drives {pause, reload, score[3:0]} asynchronously. This
// block synchronises every bit, waits for the whole word to hold still for a
// stability window, and only then publishes it. On each accepted change it also
// emits one-cycle event pulses for reload rising and for score steps.
//
// Ports:
//   clk                  system clock (65 MHz domain)
//   rst                  asynchronous, active-low reset
//   player2_pause_raw    remote pause, asynchronous
//   player2_reload_raw   remote reload, asynchronous
//   player2_score_raw    remote score, asynchronous
//   player2_pause        accepted pause level
//   player2_reload       accepted reload level
//   player2_score        accepted score
//   player2_reload_pulse one-cycle pulse on accepted reload 0->1
//   player2_score_inc    one-cycle pulse: score advanced by one (mod 16)
//   player2_score_reset  one-cycle pulse: score returned to 0 from 1..14
//   player2_score_error  one-cycle pulse: any other score change
// -----------------------------------------------------------------------------
module player_link_rx #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 65
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       player2_pause_raw,
    input  logic       player2_reload_raw,
    input  logic [3:0] player2_score_raw,
    output logic       player2_pause,
    output logic       player2_reload,
    output logic [3:0] player2_score,
    output logic       player2_reload_pulse,
    output logic       player2_score_inc,
    output logic       player2_score_reset,
    output logic       player2_score_error
);

    localparam int             CW      = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

    // Classify a score change as {inc, reset, error}; unchanged gives 3'b000.
    function automatic logic [2:0] classify_score(input logic [3:0] old_score,
                                                  input logic [3:0] new_score);
        logic [2:0] cls;
        if (new_score == old_score) begin
            cls = 3'b000;
        end else if (new_score == (old_score + 4'd1)) begin
            cls = 3'b100;               // includes the 15 -> 0 wrap
        end else if ((new_score == 4'd0) && (old_score != 4'd15)) begin
            cls = 3'b010;
        end else begin
            cls = 3'b001;
        end
        return cls;
    endfunction

    logic [5:0]    raw_s;
    logic [5:0]    sync_r [SYNC_STAGES];
    logic [5:0]    word_s;
    logic [5:0]    cand_r;
    logic [CW-1:0] cnt_r;
    logic          done_r;
    logic          accept_s;
    logic [5:0]    acc_r;
    logic          primed_r;
    logic          reload_pulse_s;
    logic [2:0]    score_cls_s;
    logic          reload_pulse_r;
    logic [2:0]    score_cls_r;

    assign raw_s  = {player2_pause_raw, player2_reload_raw, player2_score_raw};
    assign word_s = sync_r[SYNC_STAGES-1];

    // The candidate has been stable for the full window and not yet published;
    // done_r keeps this to a single accept per stable candidate.
    assign accept_s = (cnt_r == CNT_MAX) && !done_r;

    // Per-bit multi-flop synchroniser for the whole link word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 6'd0;
            end
        end else begin
            sync_r[0] <= raw_s;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Candidate tracking and saturating stability counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_r <= 6'd0;
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else if (word_s != cand_r) begin
            cand_r <= word_s;
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else begin
            if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (accept_s) begin
                done_r <= 1'b1;
            end else begin
                done_r <= done_r;
            end
        end
    end

    // Event decode from old accepted word versus the candidate being accepted.
    always_comb begin
        reload_pulse_s = 1'b0;
        score_cls_s    = 3'b000;
        if (accept_s && primed_r) begin
            reload_pulse_s = !acc_r[4] && cand_r[4];
            score_cls_s    = classify_score(acc_r[3:0], cand_r[3:0]);
        end else begin
            reload_pulse_s = 1'b0;
            score_cls_s    = 3'b000;
        end
    end

    // Accepted word, primed flag and registered event pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r          <= 6'd0;
            primed_r       <= 1'b0;
            reload_pulse_r <= 1'b0;
            score_cls_r    <= 3'b000;
        end else begin
            reload_pulse_r <= reload_pulse_s;
            score_cls_r    <= score_cls_s;
            if (accept_s) begin
                acc_r    <= cand_r;
                primed_r <= 1'b1;
            end else begin
                acc_r    <= acc_r;
                primed_r <= primed_r;
            end
        end
    end

    assign player2_pause        = acc_r[5];
    assign player2_reload       = acc_r[4];
    assign player2_score        = acc_r[3:0];
    assign player2_reload_pulse = reload_pulse_r;
    assign player2_score_inc    = score_cls_r[2];
    assign player2_score_reset  = score_cls_r[1];
    assign player2_score_error  = score_cls_r[0];

endmodule

// File: tb/tb_player_link_rx.sv
module tb_player_link_rx;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause_raw = 1'b0;
    logic       reload_raw = 1'b0;
    logic [3:0] score_raw = 4'd0;
    logic       p2_pause, p2_reload, p2_rpulse, p2_inc, p2_rst, p2_err;
    logic [3:0] p2_score;
    logic [9:0] outs;

    int total = 0;
    int bad   = 0;

    // reference model state
    int         edge_n;
    logic [5:0] run_val;
    int         run_len;
    int         due_q[$];
    logic [5:0] val_q[$];
    logic       m_primed;
    logic [5:0] m_word;
    logic [3:0] m_pulses;   // {reload_pulse, inc, reset, error}

    player_link_rx #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .player2_pause_raw    (pause_raw),
        .player2_reload_raw   (reload_raw),
        .player2_score_raw    (score_raw),
        .player2_pause        (p2_pause),
        .player2_reload       (p2_reload),
        .player2_score        (p2_score),
        .player2_reload_pulse (p2_rpulse),
        .player2_score_inc    (p2_inc),
        .player2_score_reset  (p2_rst),
        .player2_score_error  (p2_err)
    );

    always #5 clk = ~clk;

    assign outs = {p2_pause, p2_reload, p2_score, p2_rpulse, p2_inc, p2_rst, p2_err};

    task automatic model_reset();
        edge_n   = -1;
        run_val  = 6'd0;
        run_len  = SYNC + 1;   // sync chain and candidate start out holding 0
        due_q.delete();
        val_q.delete();
        m_primed = 1'b0;
        m_word   = 6'd0;
        m_pulses = 4'd0;
    endtask

    // A word is accepted SYNC+1 edges after its STABLE-th consecutive sample.
    task automatic model_step();
        logic [5:0] s;
        logic [5:0] nv;
        logic [3:0] so, sn;
        if (rst) begin
            edge_n++;
            s = {pause_raw, reload_raw, score_raw};
            m_pulses = 4'd0;
            if (s == run_val) begin
                run_len++;
            end else begin
                run_val = s;
                run_len = 1;
            end
            if (run_len == STABLE) begin
                due_q.push_back(edge_n + SYNC + 1);
                val_q.push_back(s);
            end
            if (due_q.size() > 0 && due_q[0] == edge_n) begin
                void'(due_q.pop_front());
                nv = val_q.pop_front();
                if (m_primed) begin
                    so = m_word[3:0];
                    sn = nv[3:0];
                    m_pulses[3] = !m_word[4] && nv[4];
                    if (sn != so) begin
                        if (int'(sn) == (int'(so) + 1) % 16) m_pulses[2] = 1'b1;
                        else if (sn == 4'd0 && so != 4'd15) m_pulses[1] = 1'b1;
                        else m_pulses[0] = 1'b1;
                    end
                end
                m_primed = 1'b1;
                m_word   = nv;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Apply a score value and hold it; report pulse counts and stray values.
    task automatic apply_score(input logic [3:0] v, input logic [3:0] old_v,
                               output logic [3:0] cnt3, output logic [3:0] fin,
                               output logic stray);
        cnt3  = 4'd0;
        stray = 1'b0;
        score_raw = v;
        for (int i = 0; i < 12; i++) begin
            tick();
            cnt3 = cnt3 + {1'b0, p2_inc, p2_rst, p2_err};
            if (p2_score != v && p2_score != old_v) stray = 1'b1;
        end
        fin = p2_score;
    endtask

    task automatic test_reset();
        model_reset();
        pause_raw = 1'b1; reload_raw = 1'b1; score_raw = 4'hF;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (outs !== 10'd0) begin
            bad++;
            $display("FAIL reset_async: got %b want %b", outs, 10'd0);
        end
        tick();
        total++;
        if (outs !== 10'd0) begin
            bad++;
            $display("FAIL reset_held: got %b want %b", outs, 10'd0);
        end
        pause_raw = 1'b0; reload_raw = 1'b0; score_raw = 4'd0;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (outs !== 10'd0) begin
                bad++;
                $display("FAIL reset_release cyc %0d: got %b want %b", i, outs, 10'd0);
            end
        end
    endtask

    task automatic test_score_inc();
        logic [9:0] exp;
        score_raw = 4'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i < 6)       exp = 10'b00_0000_0000;
            else if (i == 6) exp = 10'b00_0001_0100;
            else             exp = 10'b00_0001_0000;
            total++;
            if (outs !== exp) begin
                bad++;
                $display("FAIL score_inc edge %0d: got %b want %b", i, outs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        int errs;
        score_raw = 4'd3;
        repeat (3) tick();
        score_raw = 4'd1;
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (outs !== 10'b00_0001_0000) begin
                bad++;
                $display("FAIL glitch_reject cyc %0d: got %b want %b", i, outs, 10'b00_0001_0000);
            end
        end
        score_raw = 4'd3;
        errs = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            errs += int'(p2_err) + int'(p2_inc) * 10 + int'(p2_rst) * 10;
        end
        total++;
        if (p2_score !== 4'd3 || errs != 1) begin
            bad++;
            $display("FAIL glitch_accept: got score=%0d code=%0d want score=3 code=1", p2_score, errs);
        end
    endtask

    task automatic test_reload();
        int rp, sp;
        reload_raw = 1'b1;
        rp = 0; sp = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            rp += int'(p2_rpulse);
            sp += int'(p2_inc) + int'(p2_rst) + int'(p2_err);
        end
        total++;
        if (p2_reload !== 1'b1 || rp != 1 || sp != 0) begin
            bad++;
            $display("FAIL reload_rise: got lvl=%b pulses=%0d/%0d want 1 1/0", p2_reload, rp, sp);
        end
        reload_raw = 1'b0;
        rp = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            rp += int'(p2_rpulse) + int'(p2_inc) + int'(p2_rst) + int'(p2_err);
        end
        total++;
        if (p2_reload !== 1'b0 || rp != 0) begin
            bad++;
            $display("FAIL reload_fall: got lvl=%b pulses=%0d want 0 0", p2_reload, rp);
        end
    endtask

    task automatic test_score_seq();
        logic [3:0] seq_v   [9];
        logic [3:0] seq_exp [9];
        logic [3:0] cnt3, fin, prev;
        logic       stray;
        seq_v   = '{4'd14, 4'd15, 4'd0, 4'd7, 4'd0, 4'd2, 4'd9, 4'd3, 4'd4};
        // expected {0, inc, reset, error} pulse counts for each step
        seq_exp = '{4'b0001, 4'b0100, 4'b0100, 4'b0001, 4'b0010,
                    4'b0001, 4'b0001, 4'b0001, 4'b0100};
        prev = 4'd3;
        for (int k = 0; k < 9; k++) begin
            if (k == 8) begin
                score_raw = 4'b0111;   // bit 2 rises one cycle before bits 1:0 fall
                tick();
            end
            apply_score(seq_v[k], prev, cnt3, fin, stray);
            total++;
            if (cnt3 !== seq_exp[k] || fin !== seq_v[k] || stray) begin
                bad++;
                $display("FAIL score_seq %0d->%0d: got pulses=%b score=%0d stray=%b want %b %0d 0",
                         prev, seq_v[k], cnt3, fin, stray, seq_exp[k], seq_v[k]);
            end
            prev = seq_v[k];
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp;
        score_raw = 4'd5;
        repeat (3) tick();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (outs !== 10'd0) begin
            bad++;
            $display("FAIL reset_mid_async: got %b want %b", outs, 10'd0);
        end
        score_raw = 4'd6;
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = (i < 6) ? 10'd0 : 10'b00_0110_0000;
            total++;
            if (outs !== exp) begin
                bad++;
                $display("FAIL reset_mid_first edge %0d: got %b want %b", i, outs, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] w;
        int         hold;
        for (int seg = 0; seg < 80; seg++) begin
            w    = 6'($urandom);
            hold = $urandom_range(1, 7);
            {pause_raw, reload_raw, score_raw} = w;
            for (int i = 0; i < hold; i++) begin
                tick();
                total++;
                if (outs !== {m_word, m_pulses}) begin
                    bad++;
                    $display("FAIL random seg %0d: got %b want %b", seg, outs, {m_word, m_pulses});
                end
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (outs !== {m_word, m_pulses}) begin
                bad++;
                $display("FAIL random_tail %0d: got %b want %b", i, outs, {m_word, m_pulses});
            end
        end
    endtask

    initial begin
        test_reset();
        test_score_inc();
        test_glitch();
        test_reload();
        test_score_seq();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
